// File: rtl/dmg_serial_link.sv
`default_nettype none
// ============================================================================
// Module   : dmg_serial_link
// Purpose  : DMG link-cable serial port (SB at 0xFF01, SC at 0xFF02).
//            A single 8-bit shift register sends MSB-first on sout and
//            receives sin at the same time. Transfer completion clears
//            SC.start and pulses irq for one cycle. SCK is either generated
//            here (clk_int=1, master) or taken from the peer (clk_int=0).
// Ports    : clk, reset      - system clock, async active-high reset
//            wr_sb, wr_sc    - one-cycle register write strobes, data on din
//            sb, sc          - register read values
//            sck_out, sck_oe - SCK drive and its output enable (= clk_int)
//            sck_in, sin     - asynchronous pins from the peer
//            sout            - serial data out
//            irq             - one-cycle serial interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module dmg_serial_link #(
    parameter int HALF_PERIOD = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_sb,
    input  logic       wr_sc,
    input  logic [7:0] din,
    output logic [7:0] sb,
    output logic [7:0] sc,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       sck_in,
    input  logic       sin,
    output logic       sout,
    output logic       irq
);

    localparam int                 c_div_w    = $clog2(HALF_PERIOD);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(HALF_PERIOD - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_low  = 2'd1;
    localparam logic [1:0] c_st_high = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [7:0]             r_sb;
    logic                   r_start;
    logic                   r_clk_int;
    logic                   r_sck_out;
    logic                   r_sout;
    logic                   r_irq;
    logic [3:0]             r_cnt;
    logic [c_div_w-1:0]     r_div;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sin_sync;
    logic                   r_sck_prev;

    logic       w_sck_s;
    logic       w_sin_s;
    logic       w_ext_rise;
    logic       w_ext_fall;
    logic       w_rise;
    logic       w_fall;
    logic       w_done;
    logic       w_div_inc;
    logic       w_start_int;
    logic [7:0] w_sb_eff;

    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_sin_s     = r_sin_sync[SYNC_STAGES-1];
    assign w_ext_rise  = ~r_clk_int & ~r_sck_prev &  w_sck_s;
    assign w_ext_fall  = ~r_clk_int &  r_sck_prev & ~w_sck_s;
    assign w_start_int = wr_sc & din[7] & din[0];
    // A same-cycle SB write supersedes the current contents, so a transfer
    // started together with it sends the freshly written byte.
    assign w_sb_eff    = wr_sb ? din : r_sb;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and SCK edge events. LOW/HIGH mirror the SCK level in
    // both clock modes; only the event source differs.
    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_div_inc   = 1'b0;
        if (wr_sc) begin
            w_state_nxt = din[7] ? c_st_low : c_st_idle;
        end else begin
            case (r_state)
                c_st_low: begin
                    if (r_clk_int) begin
                        if (r_div == c_div_last) begin
                            w_rise      = 1'b1;
                            w_state_nxt = c_st_high;
                        end else begin
                            w_div_inc = 1'b1;
                        end
                    end else if (w_ext_rise) begin
                        w_rise      = 1'b1;
                        w_state_nxt = c_st_high;
                    end else if (w_ext_fall) begin
                        w_fall = 1'b1;
                    end
                end
                c_st_high: begin
                    if (r_clk_int) begin
                        if (r_div == c_div_last) begin
                            w_fall      = 1'b1;
                            w_state_nxt = c_st_low;
                        end else begin
                            w_div_inc = 1'b1;
                        end
                    end else if (w_ext_fall) begin
                        w_fall      = 1'b1;
                        w_state_nxt = c_st_low;
                    end else if (w_ext_rise) begin
                        w_rise = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // The eighth rising edge ends the transfer; in internal mode this
        // cuts the final HIGH phase short.
        w_done = w_rise & (r_cnt == 4'd7);
        if (w_done) begin
            w_state_nxt = c_st_idle;
        end
    end

    // Datapath, synchronisers and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb       <= 8'h00;
            r_start    <= 1'b0;
            r_clk_int  <= 1'b0;
            r_sck_out  <= 1'b1;
            r_sout     <= 1'b1;
            r_irq      <= 1'b0;
            r_cnt      <= 4'd0;
            r_div      <= '0;
            r_sck_sync <= '1;
            r_sin_sync <= '1;
            r_sck_prev <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
            r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], sin};
            r_sck_prev <= w_sck_s;
            r_irq      <= w_done;

            if (wr_sc) begin
                r_start   <= din[7];
                r_clk_int <= din[0];
            end else if (w_done) begin
                r_start <= 1'b0;
            end

            if (wr_sc || w_rise || w_fall) begin
                r_div <= '0;
            end else if (w_div_inc) begin
                r_div <= r_div + 1'b1;
            end

            if (wr_sc && din[7]) begin
                r_cnt <= 4'd0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (wr_sb) begin
                r_sb <= din;
            end else if (w_rise) begin
                r_sb <= {r_sb[6:0], w_sin_s};
            end

            if (w_start_int || w_fall) begin
                r_sout <= w_sb_eff[7];
            end

            // SCK idles high; it only goes low in internal mode.
            if (wr_sc) begin
                r_sck_out <= ~w_start_int;
            end else if (w_rise) begin
                r_sck_out <= 1'b1;
            end else if (w_fall && r_clk_int) begin
                r_sck_out <= 1'b0;
            end
        end
    end

    assign sb      = r_sb;
    assign sc      = {r_start, 6'b111111, r_clk_int};
    assign sck_out = r_sck_out;
    assign sck_oe  = r_clk_int;
    assign sout    = r_sout;
    assign irq     = r_irq;

endmodule
`default_nettype wire

// File: doc/dmg_serial_link.md
Name: dmg_serial_link

Overview:
- DMG serial port (SB/SC) that transmits and receives over the link cable, sitting between the CPU register bus and the SCK/SIN/SOUT pins.
- One 8-bit shift register shifts data out MSB-first and shifts peer data in simultaneously.
- Completion raises the serial interrupt request.
- Clock source is selectable: this end drives SCK as master, or follows the peer's SCK as slave.

Parameters:
- HALF_PERIOD, 256, clk cycles per SCK half-period in internal-clock mode. At 4.194304 MHz this gives 8192 Hz. Must be >= 2.
- SYNC_STAGES, 2, synchroniser depth on sck_in and sin. Must be >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_sb  input  1  single-cycle write strobe for SB (0xFF01)
- wr_sc  input  1  single-cycle write strobe for SC (0xFF02)
- din  input  8  write data
- sb  output  8  current shift register contents (SB read value)
- sc  output  8  SC read value: {start, 6'b111111, clk_int}
- sck_out  output  1  SCK driven when clk_int=1
- sck_oe  output  1  SCK output enable, equal to clk_int
- sck_in  input  1  external SCK, asynchronous
- sin  input  1  serial data in, asynchronous
- sout  output  1  serial data out
- irq  output  1  one-cycle serial interrupt pulse

Behaviour:
- Reset values (asynchronous): sb=0x00, start=0, clk_int=0, sck_out=1, sout=1, irq=0, bit counter=0, divider=0, FSM=IDLE, synchroniser flops=1.
- FSM states: IDLE, LOW (SCK low phase), HIGH (SCK high phase).
- Writes to SC:
  - din[7] sets start; din[0] sets clk_int.
  - If din[7]=1: enter LOW on the next cycle, bit counter=0, divider=0. This applies from any state, so a mid-transfer start restarts the transfer with no irq.
  - If din[7]=0 during a transfer: abort to IDLE with no irq. sb keeps its partially shifted value. sck_out returns to 1.
- Shifting is identical in both clock modes:
  - SCK falling edge: sout <= sb[7].
  - SCK rising edge: sb <= {sb[6:0], sin_sync}, bit counter increments.
- Internal mode (clk_int=1):
  - Entering LOW drives sck_out=0 and applies the falling-edge action.
  - Stay in each of LOW and HIGH for HALF_PERIOD cycles.
  - LOW to HIGH: sck_out=1 and the rising-edge action.
  - HIGH to LOW (counter < 8): sck_out=0 and the falling-edge action.
- External mode (clk_int=0):
  - sck_out=1, sck_oe=0.
  - Edges are detected on the synchronised sck_in. Detection latency is SYNC_STAGES+1 cycles from the pin.
  - The falling-edge action applies on a detected fall while start=1. The rising-edge action applies on a detected rise.
  - The divider is unused; FSM holds LOW/HIGH tracking the sck_in level.
- Completion, on the rising-edge action that brings the counter to 8:
  - start clears, irq=1 for exactly one cycle, FSM goes to IDLE, sck_out=1.
  - sb holds the 8 received bits and sout holds the last transmitted bit.
  - In internal mode the last HIGH phase is truncated, so total latency from the SC write to irq is 16*HALF_PERIOD-HALF_PERIOD+1 cycles.
- Writes to SB:
  - Load din immediately in any state; the bit counter is not affected.
  - wr_sb on the same cycle as a shift wins: sb=din, no shift.
  - wr_sb on the completion cycle still raises irq.
- Simultaneous wr_sc and wr_sb: both apply, and the transfer starts with the new sb.
- Edges while IDLE: ignored; sb is unchanged.
- Reset asserted mid-transfer: everything returns to reset values immediately and no irq is produced.

Test Plan:
- HALF_PERIOD=4, internal. Write sb=0xA5, sc=0x81; drive sin with 0x3C MSB-first, sampled on sck_out rise -> sout on falls = 1,0,1,0,0,1,0,1; irq one cycle at 61 cycles after the write; sb=0x3C; sc=0x7F.
- External. Write sb=0x0F, sc=0x80; bench toggles sck_in 8 times (8-cycle halves) with sin=1 -> sb=0xFF, sout sequence 0,0,0,0,1,1,1,1, irq once, sck_oe=0 throughout.
- Abort: internal transfer. After 3 rising edges write sc=0x01 -> FSM IDLE, sck_out=1, no irq, sb shows 3 shifted bits; a later sc=0x81 runs a full 8-bit transfer.
- External mode, start=0: toggle sck_in 8 times -> sb unchanged, irq stays 0.
- wr_sb on the completion cycle with din=0x55 -> sb=0x55 and irq still pulses.
- Assert reset after 5 bits of an internal transfer -> sb=0x00, sc=0x7E, sck_out=1, sout=1, no irq ever.
